// File: rtl/brdtst_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : brdtst_uart_tx                                               |
// | Description : Board-test UART transmitter. Accepts bytes over a            |
// |               valid/ready handshake into a one-byte holding register and   |
// |               serializes them as 8N1/8N2 frames. It also drives nRTS and   |
// |               the RS-485 driver enable, with lead/tail turnaround guards.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module brdtst_uart_tx #(
  parameter int BAUD_DIV  = 256,  // clk cycles per bit time, 2..65535
  parameter int LEAD_BITS = 1,    // guard bit times before the start bit, 0..3
  parameter int STOP_BITS = 1,    // stop bits per frame, 1 or 2
  parameter int TAIL_BITS = 1     // guard bit times after the last stop bit, 0..3
) (
  input  logic       Clk,
  input  logic       nRst,
  input  logic [7:0] TxData,
  input  logic       TxValid,
  output logic       TxReady,
  output logic       TxD,
  output logic       nRTS,
  output logic       DE,
  output logic       Busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4,
    S_TAIL  = 3'd5
  } state_t;

  // Last count value of each counted phase. A phase with zero bit times is
  // never entered, so its wrapped "last" value is never compared against.
  localparam logic [15:0] c_BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  c_LEAD_LAST = 3'(LEAD_BITS - 1);
  localparam logic [2:0]  c_DATA_LAST = 3'd7;
  localparam logic [2:0]  c_STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [2:0]  c_TAIL_LAST = 3'(TAIL_BITS - 1);
  localparam bit          c_HAS_LEAD  = (LEAD_BITS > 0);
  localparam bit          c_HAS_TAIL  = (TAIL_BITS > 0);

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  // Delayed copy of the holding-register flag: IDLE reacts to it so that a
  // fresh byte leaves IDLE two edges after its accept.
  logic        start_req_q;
  logic        txd_q, txd_d;
  logic        nrts_q, nrts_d;
  logic        de_q, de_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic        w_bit_end;
  logic        w_accept;
  logic        w_load;

  assign w_bit_end = (baud_q == c_BAUD_LAST);
  // TxReady is the registered complement of the holding flag, so an accept
  // can only happen while the holding register is empty.
  assign w_accept  = TxValid & ready_q;

  // Baud counter: idle at zero, restarts on every bit boundary (and thus on
  // every state entry, since states only change on bit boundaries).
  always_comb begin
    baud_d = baud_q + 16'd1;
    if ((state_q == S_IDLE) || w_bit_end) begin
      baud_d = '0;
    end
  end

  // Next-state, bit counter, shift register and holding register logic.
  always_comb begin
    state_d     = state_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    w_load      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_req_q && hold_full_q) begin
          bit_d = 3'd0;
          if (c_HAS_LEAD) begin
            state_d = S_LEAD;
          end else begin
            state_d = S_START;
            w_load  = 1'b1;
          end
        end
      end

      S_LEAD: begin
        if (w_bit_end) begin
          if (bit_q == c_LEAD_LAST) begin
            state_d = S_START;
            bit_d   = 3'd0;
            w_load  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      S_START: begin
        if (w_bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end

      S_DATA: begin
        if (w_bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == c_DATA_LAST) begin
            state_d = S_STOP;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      S_STOP: begin
        if (w_bit_end) begin
          if (bit_q == c_STOP_LAST) begin
            bit_d = 3'd0;
            if (hold_full_q) begin
              // Back-to-back frame: no guard time between the frames.
              state_d = S_START;
              w_load  = 1'b1;
            end else if (c_HAS_TAIL) begin
              state_d = S_TAIL;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      S_TAIL: begin
        // A byte arriving here waits: TAIL always completes through IDLE.
        if (w_bit_end) begin
          if (bit_q == c_TAIL_LAST) begin
            state_d = S_IDLE;
            bit_d   = 3'd0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        bit_d   = 3'd0;
      end
    endcase

    // Move the held byte into the shift register on START entry.
    if (w_load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
    end

    if (w_accept) begin
      hold_d      = TxData;
      hold_full_d = 1'b1;
    end
  end

  // Output decode from the next state so every output is a plain flop that
  // changes together with the state it belongs to.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
    de_d    = (state_d != S_IDLE);
    nrts_d  = ~de_d;
    ready_d = ~hold_full_d;
    busy_d  = de_d | hold_full_d;
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      start_req_q <= 1'b0;
      txd_q       <= 1'b1;
      nrts_q      <= 1'b1;
      de_q        <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      start_req_q <= hold_full_q;
      txd_q       <= txd_d;
      nrts_q      <= nrts_d;
      de_q        <= de_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign TxReady = ready_q;
  assign TxD     = txd_q;
  assign nRTS    = nrts_q;
  assign DE      = de_q;
  assign Busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_brdtst_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_brdtst_uart_tx                                            |
// | Description : Self-checking bench for brdtst_uart_tx. Two instances with   |
// |               different frame parameters; expected line activity is built |
// |               bit by bit from the frame rules.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_brdtst_uart_tx;

  logic       Clk = 1'b0;
  logic       nRst;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_rdy, a_txd, a_nrts, a_de, a_busy;
  logic       b_rdy, b_txd, b_nrts, b_de, b_busy;

  always #5 Clk = ~Clk;

  brdtst_uart_tx #(.BAUD_DIV(4), .LEAD_BITS(1), .STOP_BITS(1), .TAIL_BITS(1)) u_dut_a (
    .Clk(Clk), .nRst(nRst), .TxData(a_data), .TxValid(a_valid), .TxReady(a_rdy),
    .TxD(a_txd), .nRTS(a_nrts), .DE(a_de), .Busy(a_busy)
  );

  brdtst_uart_tx #(.BAUD_DIV(2), .LEAD_BITS(0), .STOP_BITS(2), .TAIL_BITS(0)) u_dut_b (
    .Clk(Clk), .nRst(nRst), .TxData(b_data), .TxValid(b_valid), .TxReady(b_rdy),
    .TxD(b_txd), .nRTS(b_nrts), .DE(b_de), .Busy(b_busy)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Frame request list: byte, chained (offered as soon as the previous
  // byte starts) and explicit offer cycle for non-chained follow-ups.
  logic [7:0] fr_byte[$];
  bit         fr_chain[$];
  int         fr_offer[$];

  // Expected per-cycle line activity, index 0 = cycle after the first accept.
  bit exp_txd[$], exp_de[$], exp_rdy[$];
  int start_idx[$], offer_idx[$], acc_idx[$];

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic push_bits(input bit txd, input bit de, input int n);
    for (int i = 0; i < n; i++) begin
      exp_txd.push_back(txd);
      exp_de.push_back(de);
    end
  endtask

  task automatic build_model(input int baud, input int lead, input int stop, input int tail);
    int n;
    bit last, next_gap, r;
    exp_txd.delete(); exp_de.delete(); exp_rdy.delete();
    start_idx.delete(); offer_idx.delete(); acc_idx.delete();
    n = fr_byte.size();
    push_bits(1'b1, 1'b0, 2);  // two cycles of IDLE with the byte held
    for (int k = 0; k < n; k++) begin
      last     = (k == n - 1);
      next_gap = !last && !fr_chain[k + 1];
      if (k == 0 || !fr_chain[k]) push_bits(1'b1, 1'b1, lead * baud);
      start_idx.push_back(exp_txd.size());
      push_bits(1'b0, 1'b1, baud);
      for (int b = 0; b < 8; b++) push_bits(fr_byte[k][b], 1'b1, baud);
      push_bits(1'b1, 1'b1, stop * baud);
      if (last || next_gap) push_bits(1'b1, 1'b1, tail * baud);
      if (next_gap) push_bits(1'b1, 1'b0, 1);
    end
    push_bits(1'b1, 1'b0, 8);
    for (int k = 0; k < n; k++) begin
      if (k == 0)           offer_idx.push_back(-1);
      else if (fr_chain[k]) offer_idx.push_back(start_idx[k - 1]);
      else                  offer_idx.push_back(fr_offer[k]);
      acc_idx.push_back(offer_idx[k] + 1);
    end
    // Holding register is full from the accept until the byte's START.
    for (int j = 0; j < exp_txd.size(); j++) begin
      r = 1'b1;
      for (int k = 0; k < n; k++)
        if (acc_idx[k] <= j && j < start_idx[k]) r = 1'b0;
      exp_rdy.push_back(r);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin b_valid = v; b_data = d; end
    else     begin a_valid = v; a_data = d; end
  endtask

  task automatic check_outputs(input bit sel, input string tag, input bit txd, input bit de,
                               input bit rdy, input bit busy);
    chk1({tag, ".txd"},  sel ? b_txd  : a_txd,  txd);
    chk1({tag, ".de"},   sel ? b_de   : a_de,   de);
    chk1({tag, ".nrts"}, sel ? b_nrts : a_nrts, !de);
    chk1({tag, ".rdy"},  sel ? b_rdy  : a_rdy,  rdy);
    chk1({tag, ".busy"}, sel ? b_busy : a_busy, busy);
  endtask

  task automatic idle_check(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clk);
      check_outputs(1'b0, $sformatf("%s_a[%0d]", tag, i), 1'b1, 1'b0, 1'b1, 1'b0);
      check_outputs(1'b1, $sformatf("%s_b[%0d]", tag, i), 1'b1, 1'b0, 1'b1, 1'b0);
    end
  endtask

  // Called at a negedge: offers the first byte, then compares every cycle.
  task automatic run_stream(input bit sel, input int abort_at, input int de_len, input string name);
    int k, n, de_cnt;
    k = 1; n = fr_byte.size(); de_cnt = 0;
    drive(sel, 1'b1, fr_byte[0]);
    for (int j = 0; j < exp_txd.size(); j++) begin
      @(negedge Clk);
      check_outputs(sel, $sformatf("%s[%0d]", name, j), exp_txd[j], exp_de[j], exp_rdy[j],
                    exp_de[j] | !exp_rdy[j]);
      if (sel ? b_de : a_de) de_cnt++;
      if (j == abort_at) begin
        drive(sel, 1'b0, 8'h00);
        nRst = 1'b0;
        return;
      end
      if (k < n && j == offer_idx[k]) begin
        drive(sel, 1'b1, fr_byte[k]);
        k++;
      end else if (k < n && fr_chain[k]) begin
        drive(sel, 1'b1, 8'($urandom));  // held valid with ready low: ignored
      end else begin
        drive(sel, 1'b0, 8'($urandom));
      end
    end
    chk_n({name, ".de_len"}, de_cnt, de_len);
  endtask

  initial begin
    logic [7:0] rb0, rb1;
    bit         rch, rsel;
    nRst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00;
    idle_check(3, "reset");
    nRst = 1'b1;
    idle_check(100, "idle");

    // Single byte, default guards.
    fr_byte = '{8'hA5}; fr_chain = '{1'b0}; fr_offer = '{0};
    build_model(4, 1, 1, 1);
    run_stream(1'b0, -1, 48, "a5");

    // Back-to-back with TxValid held high.
    fr_byte = '{8'h00, 8'hFF}; fr_chain = '{1'b0, 1'b1}; fr_offer = '{0, 0};
    build_model(4, 1, 1, 1);
    run_stream(1'b0, -1, 88, "b2b");

    // Second byte offered in the first TAIL cycle (index 46).
    fr_byte = '{8'h12, 8'h34}; fr_chain = '{1'b0, 1'b0}; fr_offer = '{0, 46};
    build_model(4, 1, 1, 1);
    run_stream(1'b0, -1, 96, "tail");

    // Reset during DATA bit 3 of 0x55 while a second byte is held.
    fr_byte = '{8'h55, 8'hAA}; fr_chain = '{1'b0, 1'b1}; fr_offer = '{0, 0};
    build_model(4, 1, 1, 1);
    run_stream(1'b0, 24, -1, "abort");
    idle_check(2, "in_reset");
    nRst = 1'b1;
    idle_check(60, "post_reset");

    // No lead/tail, two stop bits, fast baud.
    fr_byte = '{8'h3C}; fr_chain = '{1'b0}; fr_offer = '{0};
    build_model(2, 0, 2, 0);
    run_stream(1'b1, -1, 22, "b3c");

    // Randomized bytes, single or chained, on both instances.
    for (int r = 0; r < 8; r++) begin
      rb0  = 8'($urandom);
      rb1  = 8'($urandom);
      rch  = 1'($urandom_range(0, 1));
      rsel = 1'(r);
      if (rch) begin
        fr_byte = '{rb0, rb1}; fr_chain = '{1'b0, 1'b1}; fr_offer = '{0, 0};
      end else begin
        fr_byte = '{rb0}; fr_chain = '{1'b0}; fr_offer = '{0};
      end
      if (rsel) build_model(2, 0, 2, 0);
      else      build_model(4, 1, 1, 1);
      run_stream(rsel, -1,
                 rsel ? (rch ? 2 * 2 * 11 : 2 * 11) : (rch ? 4 * 22 : 4 * 12),
                 $sformatf("rnd%0d", r));
    end
    idle_check(5, "end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
